// File: rtl/pipe_mux_pkg.sv
// Shared constants and helpers for the registered N:1 valid/ready multiplexer.
package pipe_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Smallest r with 2**r >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter
  import pipe_mux_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] w_req2;
  logic [2*N-1:0] w_shift;
  logic [N-1:0]   w_rot;
  logic           w_found;

  // Duplicating the request vector turns the wrap-around search into a plain shift.
  assign w_req2  = {req, req};
  assign w_shift = w_req2 >> ptr;
  assign w_rot   = w_shift[N-1:0];

  // Priority search, lowest rotated offset wins.
  always_comb begin
    w_found = 1'b0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        idx     = (int'(ptr) + k >= N) ? IW'(int'(ptr) + k - N) : IW'(int'(ptr) + k);
      end else begin
        idx     = idx;
      end
    end
  end

  // One-hot form of idx.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = w_found && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/pipe_mux_rr.sv
// Registered N:1 multiplexer with valid/ready on every channel, explicit or round-robin select.
module pipe_mux_rr
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int MODE     = MODE_SEL,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          xfer_cnt
);

  logic [CHANNELS-1:0] w_grant;
  logic [SEL_W-1:0]    w_gidx;
  logic                w_slot_free;
  logic                w_xfer;
  logic [WIDTH-1:0]    w_data;

  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_chan;
  logic                r_out_valid;
  logic [CNT_W-1:0]    r_xfer_cnt;

  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = w_grant & {CHANNELS{w_slot_free}};
  assign w_xfer      = |(in_valid & in_ready);

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SEL_W-1:0] r_rr_ptr;

      rr_arbiter #(
        .N  (CHANNELS),
        .IW (SEL_W)
      ) u_arb (
        .req (in_valid),
        .ptr (r_rr_ptr),
        .gnt (w_grant),
        .idx (w_gidx)
      );

      // Pointer moves past the winner so it has lowest priority next time.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_rr_ptr <= '0;
        end else if (w_xfer) begin
          r_rr_ptr <= (w_gidx == SEL_W'(CHANNELS - 1)) ? '0 : w_gidx + SEL_W'(1);
        end
      end
    end else begin : g_sel
      // Out-of-range select matches no channel, so nothing is granted.
      always_comb begin
        w_grant = '0;
        for (int i = 0; i < CHANNELS; i++) begin
          w_grant[i] = (sel == SEL_W'(i));
        end
      end

      assign w_gidx = sel;
    end
  endgenerate

  // Data select driven from the one-hot grant keeps every slice in range.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant[i]) begin
        w_data = in_data[i*WIDTH +: WIDTH];
      end else begin
        w_data = w_data;
      end
    end
  end

  // One-entry output register; holds under backpressure, drains when no new word arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_xfer_cnt  <= '0;
    end else if (w_xfer) begin
      r_out_data  <= w_data;
      r_out_chan  <= w_gidx;
      r_out_valid <= 1'b1;
      r_xfer_cnt  <= r_xfer_cnt + CNT_W'(1);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;
  assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_pipe_mux_rr.sv
// Scoreboard bench: explicit-select, round-robin and 5-channel instances driven with directed vectors.
module tb_pipe_mux_rr;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // u_sel: MODE 0, 8 channels
  logic [31:0] s_in_data;
  logic [7:0]  s_in_valid, s_in_ready;
  logic [2:0]  s_sel, s_out_chan;
  logic [3:0]  s_out_data;
  logic        s_out_valid, s_out_ready;
  logic [15:0] s_xfer_cnt;

  // u_rr: MODE 1, 8 channels
  logic [31:0] r_in_data;
  logic [7:0]  r_in_valid, r_in_ready;
  logic [2:0]  r_sel, r_out_chan;
  logic [3:0]  r_out_data;
  logic        r_out_valid, r_out_ready;
  logic [15:0] r_xfer_cnt;

  // u_c5: MODE 0, 5 channels
  logic [19:0] c_in_data;
  logic [4:0]  c_in_valid, c_in_ready;
  logic [2:0]  c_sel, c_out_chan;
  logic [3:0]  c_out_data;
  logic        c_out_valid, c_out_ready;
  logic [15:0] c_xfer_cnt;

  logic [6:0] q_sel[$];
  logic [6:0] q_rr[$];
  logic [6:0] q_c5[$];

  pipe_mux_rr #(.WIDTH(4), .CHANNELS(8), .SEL_W(3), .MODE(0), .CNT_W(16)) u_sel (
    .clk(clk), .reset(reset), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .sel(s_sel), .out_data(s_out_data), .out_chan(s_out_chan), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .xfer_cnt(s_xfer_cnt));

  pipe_mux_rr #(.WIDTH(4), .CHANNELS(8), .SEL_W(3), .MODE(1), .CNT_W(16)) u_rr (
    .clk(clk), .reset(reset), .in_data(r_in_data), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .sel(r_sel), .out_data(r_out_data), .out_chan(r_out_chan), .out_valid(r_out_valid),
    .out_ready(r_out_ready), .xfer_cnt(r_xfer_cnt));

  pipe_mux_rr #(.WIDTH(4), .CHANNELS(5), .SEL_W(3), .MODE(0), .CNT_W(16)) u_c5 (
    .clk(clk), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .sel(c_sel), .out_data(c_out_data), .out_chan(c_out_chan), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .xfer_cnt(c_xfer_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop one expected {chan,data} per accepted output word.
  always @(negedge clk) begin
    if (s_out_valid && s_out_ready) begin
      if (q_sel.size() == 0) begin
        n_checks++;
        $display("FAIL sel_unexpected: got chan %0d data %h, expected no word", s_out_chan, s_out_data);
      end else chk("sel_word", 32'({s_out_chan, s_out_data}), 32'(q_sel.pop_front()));
    end
    if (r_out_valid && r_out_ready) begin
      if (q_rr.size() == 0) begin
        n_checks++;
        $display("FAIL rr_unexpected: got chan %0d data %h, expected no word", r_out_chan, r_out_data);
      end else chk("rr_word", 32'({r_out_chan, r_out_data}), 32'(q_rr.pop_front()));
    end
    if (c_out_valid && c_out_ready) begin
      if (q_c5.size() == 0) begin
        n_checks++;
        $display("FAIL c5_unexpected: got chan %0d data %h, expected no word", c_out_chan, c_out_data);
      end else chk("c5_word", 32'({c_out_chan, c_out_data}), 32'(q_c5.pop_front()));
    end
  end

  initial begin
    reset = 1'b1;
    s_in_data = '0; s_in_valid = '0; s_sel = '0; s_out_ready = 1'b0;
    r_in_data = '0; r_in_valid = '0; r_sel = '0; r_out_ready = 1'b0;
    c_in_data = '0; c_in_valid = '0; c_sel = '0; c_out_ready = 1'b0;
    #3;
    chk("rst_s_valid", 32'(s_out_valid), 32'd0);
    chk("rst_s_data",  32'(s_out_data),  32'd0);
    chk("rst_s_cnt",   32'(s_xfer_cnt),  32'd0);
    chk("rst_r_valid", 32'(r_out_valid), 32'd0);
    chk("rst_c_valid", 32'(c_out_valid), 32'd0);
    tick();
    reset = 1'b0;

    // T1: explicit select of channel 5
    s_sel = 3'd5; s_in_valid = 8'h20; s_in_data = 32'h00A0_0000; s_out_ready = 1'b1;
    #1 chk("t1_in_ready", 32'(s_in_ready), 32'h20);
    q_sel.push_back({3'd5, 4'hA});
    tick();
    chk("t1_data", 32'(s_out_data), 32'hA);
    chk("t1_chan", 32'(s_out_chan), 32'd5);
    chk("t1_cnt",  32'(s_xfer_cnt), 32'd1);

    // T2: three cycles of backpressure, then the next word
    s_out_ready = 1'b0; s_in_data = 32'h0070_0000;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t2_in_ready_bp", 32'(s_in_ready), 32'h00);
      tick();
      chk("t2_hold_data",  32'(s_out_data),  32'hA);
      chk("t2_hold_valid", 32'(s_out_valid), 32'd1);
    end
    s_out_ready = 1'b1;
    #1 chk("t2_in_ready", 32'(s_in_ready), 32'h20);
    q_sel.push_back({3'd5, 4'h7});
    tick();
    chk("t2_cnt", 32'(s_xfer_cnt), 32'd2);
    s_in_valid = 8'h00;
    tick();
    chk("t2_drain_valid", 32'(s_out_valid), 32'd0);
    chk("t2_drain_data",  32'(s_out_data),  32'h7);
    chk("t2_drain_chan",  32'(s_out_chan),  32'd5);

    // T3: round-robin over all channels; channel i carries 15-i
    r_in_data = 32'h89AB_CDEF; r_in_valid = 8'hFF; r_out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1 chk("t3_in_ready", 32'(r_in_ready), 32'(8'h01 << (k % 8)));
      q_rr.push_back({3'(k % 8), 4'(15 - (k % 8))});
      tick();
    end
    chk("t3_cnt", 32'(r_xfer_cnt), 32'd10);

    // T4: pointer at 2 -> ch5 moves it to 6; then 8'h05 gives ch0, ch2, ch0
    r_in_valid = 8'h20;
    #1 chk("t4_setup", 32'(r_in_ready), 32'h20);
    q_rr.push_back({3'd5, 4'hA});
    tick();
    r_in_valid = 8'h05;
    #1 chk("t4_g0", 32'(r_in_ready), 32'h01);
    q_rr.push_back({3'd0, 4'hF});
    tick();
    #1 chk("t4_g2", 32'(r_in_ready), 32'h04);
    q_rr.push_back({3'd2, 4'hD});
    tick();
    #1 chk("t4_g0_wrap", 32'(r_in_ready), 32'h01);
    q_rr.push_back({3'd0, 4'hF});
    tick();
    r_in_valid = 8'h00;
    #1 chk("t4_idle_ready", 32'(r_in_ready), 32'h00);
    tick();
    tick();
    chk("t4_idle_valid", 32'(r_out_valid), 32'd0);
    r_in_valid = 8'h05;
    #1 chk("t4_ptr_held", 32'(r_in_ready), 32'h04);
    q_rr.push_back({3'd2, 4'hD});
    tick();
    r_out_ready = 1'b0;
    #1 chk("t4_bp_ready", 32'(r_in_ready), 32'h00);
    tick();
    chk("t4_bp_chan", 32'(r_out_chan), 32'd2);
    r_out_ready = 1'b1; r_in_valid = 8'h00;
    tick();
    tick();

    // T5: five channels, sel beyond range grants nothing; then sel changes each cycle
    c_in_data = 20'hC_1234; c_in_valid = 5'h1F; c_sel = 3'd6; c_out_ready = 1'b1;
    #1 chk("t5_oob_ready", 32'(c_in_ready), 32'h00);
    tick();
    tick();
    chk("t5_oob_valid", 32'(c_out_valid), 32'd0);
    chk("t5_oob_cnt",   32'(c_xfer_cnt),  32'd0);
    c_sel = 3'd4;
    #1 chk("t5_sel4", 32'(c_in_ready), 32'h10);
    q_c5.push_back({3'd4, 4'hC});
    tick();
    c_sel = 3'd1;
    #1 chk("t5_sel1", 32'(c_in_ready), 32'h02);
    q_c5.push_back({3'd1, 4'h3});
    tick();
    c_in_valid = 5'h00;
    tick();
    chk("t5_cnt",   32'(c_xfer_cnt),  32'd2);
    chk("t5_drain", 32'(c_out_valid), 32'd0);

    // T6: stream on channel 3 until xfer_cnt reaches 0xFFFF, wrap it, then reset mid-word
    s_sel = 3'd3; s_in_valid = 8'h08; s_out_ready = 1'b1;
    for (int k = 0; k < 65533; k++) begin
      s_in_data = {8{4'(k)}};
      q_sel.push_back({3'd3, 4'(k)});
      tick();
    end
    chk("t6_cnt_max", 32'(s_xfer_cnt), 32'h0000_FFFF);
    s_in_data = {8{4'h9}};
    q_sel.push_back({3'd3, 4'h9});
    tick();
    chk("t6_cnt_wrap", 32'(s_xfer_cnt), 32'd0);
    s_out_ready = 1'b0; s_in_valid = 8'h00;
    #1 chk("t6_pre_valid", 32'(s_out_valid), 32'd1);
    reset = 1'b1;
    q_sel.delete();
    #1;
    chk("t6_rst_valid", 32'(s_out_valid), 32'd0);
    chk("t6_rst_data",  32'(s_out_data),  32'd0);
    chk("t6_rst_chan",  32'(s_out_chan),  32'd0);
    chk("t6_rst_cnt",   32'(s_xfer_cnt),  32'd0);
    tick();
    reset = 1'b0;
    s_sel = 3'd5; s_in_valid = 8'h20; s_in_data = 32'h00B0_0000; s_out_ready = 1'b1;
    q_sel.push_back({3'd5, 4'hB});
    tick();
    chk("t6_recover_cnt", 32'(s_xfer_cnt), 32'd1);
    s_in_valid = 8'h00;
    tick();
    tick();

    chk("q_sel_empty", 32'(q_sel.size()), 32'd0);
    chk("q_rr_empty",  32'(q_rr.size()),  32'd0);
    chk("q_c5_empty",  32'(q_c5.size()),  32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
